fetch_sequencer: RTL and testbench

//  Multi-cycle control FSM for the RISC-V core. Owns the architectural PC and

---
 rtl/rv_ctrl_pkg.sv | 25 ++
 rtl/next_pc_unit.sv | 29 ++
 rtl/fetch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared types for the multi-cycle fetch/execute sequencer.
// MISALIGN_TRAP_EN adds the TRAP state to the sequencer state set.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
`ifdef MISALIGN_TRAP_EN
    , TRAP    = 3'd5
`endif
  } seq_state_t;

  // 2'b11 has no enumerator and falls back to the sequential step.
  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JALR = 2'b10
  } pc_sel_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/next_pc_unit.sv
// Combinational next-PC select: sequential step, branch target or jalr target.
// Without MISALIGN_TRAP_EN the result is forced word aligned; with it, raw bits pass through.
module next_pc_unit
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  pc_sel_t         pc_sel,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] raw;

  always_comb begin
    case (pc_sel)
      PC_BR:   raw = branch_target;
      PC_JALR: raw = branch_target & ~XLEN'(1);
      default: raw = pc + XLEN'(PC_STEP);
    endcase
`ifdef MISALIGN_TRAP_EN
    next_pc = raw;
`else
    next_pc = raw & ~XLEN'(3);
`endif
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction sequencer: owns PC/IR and the imem/dmem request handshakes.
// MISALIGN_TRAP_EN enables the sticky misaligned-target TRAP state.
//
// state     | meaning
// FETCH     | request instruction at pc, wait for imem_ack
// DECODE    | capture decoder flags and pc_sel
// EXECUTE   | capture next_pc, choose MEM or WRITEBACK
// MEM       | request data access, wait for dmem_ack
// WRITEBACK | rf_we/instr_done pulse, commit next_pc
// TRAP      | misaligned target, halted until reset
module fetch_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  input  logic            dec_mem_op,
  input  logic            dec_wb,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] branch_target,
  output logic            dmem_req,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_done,
  output logic            trap
);

  seq_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, next_pc_q, next_pc_d, next_pc_c;
  logic [31:0]     ir_q, ir_d;
  logic            imem_req_q, imem_req_d, dmem_req_q, dmem_req_d;
  logic            rf_we_q, rf_we_d, instr_done_q, instr_done_d;
  logic            mem_op_q, mem_op_d, wb_q, wb_d;
  pc_sel_t         pc_sel_q, pc_sel_d;
`ifdef MISALIGN_TRAP_EN
  logic            trap_q, trap_d;
`endif

  next_pc_unit #(.XLEN(XLEN)) u_next_pc (
    .pc            (pc_q),
    .pc_sel        (pc_sel_q),
    .branch_target (branch_target),
    .next_pc       (next_pc_c)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    next_pc_d    = next_pc_q;
    mem_op_d     = mem_op_q;
    wb_d         = wb_q;
    pc_sel_d     = pc_sel_q;
    imem_req_d   = 1'b0;
    dmem_req_d   = 1'b0;
    rf_we_d      = 1'b0;
    instr_done_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap_d       = trap_q;
`endif
    case (state_q)
      // Acks only count while our own registered request is high.
      FETCH: begin
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      DECODE: begin
        mem_op_d = dec_mem_op;
        wb_d     = dec_wb;
        pc_sel_d = pc_sel_t'(pc_sel);
        state_d  = EXECUTE;
      end
      EXECUTE: begin
        next_pc_d = next_pc_c;
`ifdef MISALIGN_TRAP_EN
        if (next_pc_c[1:0] != 2'b00) begin
          state_d = TRAP;
          trap_d  = 1'b1;
        end else
`endif
        if (mem_op_q) begin
          state_d = MEM;
        end else begin
          state_d      = WRITEBACK;
          rf_we_d      = wb_q;
          instr_done_d = 1'b1;
        end
      end
      MEM: begin
        if (dmem_req_q && dmem_ack) begin
          state_d      = WRITEBACK;
          rf_we_d      = wb_q;
          instr_done_d = 1'b1;
        end else begin
          dmem_req_d = 1'b1;
        end
      end
      WRITEBACK: begin
        pc_d    = next_pc_q;
        state_d = FETCH;
      end
`ifdef MISALIGN_TRAP_EN
      TRAP: state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      next_pc_q    <= RESET_PC;
      mem_op_q     <= 1'b0;
      wb_q         <= 1'b0;
      pc_sel_q     <= PC_SEQ;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      rf_we_q      <= 1'b0;
      instr_done_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      next_pc_q    <= next_pc_d;
      mem_op_q     <= mem_op_d;
      wb_q         <= wb_d;
      pc_sel_q     <= pc_sel_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      rf_we_q      <= rf_we_d;
      instr_done_q <= instr_done_d;
`ifdef MISALIGN_TRAP_EN
      trap_q       <= trap_d;
`endif
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign ir         = ir_q;
  assign dmem_req   = dmem_req_q;
  assign rf_we      = rf_we_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + XLEN'(PC_STEP);
  assign instr_done = instr_done_q;
`ifdef MISALIGN_TRAP_EN
  assign trap       = trap_q;
`else
  assign trap       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: models next-PC, latency and pulse counts per instruction.
// Honours MISALIGN_TRAP_EN for the misaligned-target scenario.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, ir;
  logic        dec_mem_op = 1'b0, dec_wb = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] branch_target = '0;
  logic        dmem_req, dmem_ack = 1'b0, rf_we, instr_done, trap;
  logic [31:0] pc, pc_plus4;

  fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .dec_mem_op(dec_mem_op), .dec_wb(dec_wb),
    .pc_sel(pc_sel), .branch_target(branch_target), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc(pc), .pc_plus4(pc_plus4), .instr_done(instr_done), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cycles, ireq, dreq, we, done, first_req;
    bit addr_ok, ir_ok, pc_stable, timed_out;
    logic [31:0] p4, pc_after, ir_after;
  } obs_t;

  typedef struct {
    logic [31:0] pc;
    int cycles, we, ireq, dreq;
    bit trap;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] model_pc = 32'h0;
  logic [31:0] model_ir = 32'h0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] model_next(logic [31:0] cur, logic [1:0] sel, logic [31:0] tgt);
    logic [31:0] n;
    case (sel)
      2'b01:   n = tgt;
      2'b10:   n = tgt & 32'hFFFF_FFFE;
      default: n = cur + 32'd4;
    endcase
`ifdef MISALIGN_TRAP_EN
    return {(n[1:0] != 2'b00), n};
`else
    return {1'b0, n & 32'hFFFF_FFFC};
`endif
  endfunction

  // Acts as imem/dmem/decoder for one instruction; decode flags and target are valid only
  // in the cycle the sequencer is meant to sample them, inverted otherwise.
  task automatic run_instr(input logic [31:0] rdata, input int iwait, input bit mem, input bit wb,
                           input logic [1:0] sel, input logic [31:0] tgt, input int dwait,
                           input bit spur, input int max_cyc, output obs_t o);
    exp_t e;
    logic [32:0] m;
    int acked;
    bit fin;
    m = model_next(model_pc, sel, tgt);
    e.trap = m[32];
    e.pc = m[32] ? model_pc : m[31:0];
    e.cycles = 5 + iwait + (mem ? 2 + dwait : 0);
    e.we = (wb && !m[32]) ? 1 : 0;
    e.ireq = iwait + 1;
    e.dreq = mem ? dwait + 1 : 0;
    sb.push_back(e);
    o = '{default: 0};
    o.addr_ok = 1; o.ir_ok = 1; o.pc_stable = 1;
    o.p4 = pc_plus4;
    acked = -10;
    fin = 0;
    for (int c = 1; c <= max_cyc && !fin; c++) begin
      o.cycles = c;
      if (pc !== model_pc) o.pc_stable = 0;
      if ((acked > 0 && c > acked) ? (ir !== rdata) : (ir !== model_ir)) o.ir_ok = 0;
      imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      if (imem_req) begin
        o.ireq++;
        if (o.first_req == 0) o.first_req = c;
        if (imem_addr !== model_pc) o.addr_ok = 0;
        if (o.ireq > iwait) begin imem_ack = 1'b1; imem_rdata = rdata; acked = c; end
      end else imem_ack = spur;
      if (dmem_req) begin
        o.dreq++;
        if (o.dreq > dwait) dmem_ack = 1'b1;
      end else dmem_ack = spur;
      dec_mem_op    = (c == acked + 1) ? mem : !mem;
      dec_wb        = (c == acked + 1) ? wb : !wb;
      pc_sel        = (c == acked + 1) ? sel : ~sel;
      branch_target = (c == acked + 2) ? tgt : ~tgt;
      if (rf_we) o.we++;
      if (instr_done) begin o.done++; fin = 1; end
      step;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    o.timed_out = !fin;
    o.pc_after = pc;
    o.ir_after = ir;
    model_pc = e.pc;
    if (acked > 0) model_ir = rdata;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step;
    n_assert++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_imem_req got %b want 0", imem_req); end
    n_assert++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_dmem_req got %b want 0", dmem_req); end
    n_assert++; if ({rf_we, instr_done, trap} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses got %b want 000", {rf_we, instr_done, trap}); end
    n_assert++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 00000000", pc); end
    n_assert++; if (ir !== 32'h0) begin n_fail++; $display("FAIL rst_ir got %h want 00000000", ir); end
    rst = 1'b0;
    model_pc = 32'h0; model_ir = 32'h0;
  endtask

  task automatic test_basic;
    obs_t o; exp_t e;
    run_instr(32'h0000_0013, 0, 1'b0, 1'b1, 2'b00, 32'h0, 0, 1'b0, 40, o);
    e = sb.pop_front();
    n_assert++; if (o.first_req !== 2) begin n_fail++; $display("FAIL basic_req_rise got cycle %0d want 2", o.first_req); end
    n_assert++; if (o.addr_ok !== 1'b1) begin n_fail++; $display("FAIL basic_imem_addr got bad addr want %h", 32'h0); end
    n_assert++; if (o.cycles !== e.cycles || o.timed_out) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", o.cycles, e.cycles); end
    n_assert++; if (o.pc_after !== e.pc) begin n_fail++; $display("FAIL basic_pc got %h want %h", o.pc_after, e.pc); end
    n_assert++; if (o.we !== e.we || o.done !== 1) begin n_fail++; $display("FAIL basic_pulses got we=%0d done=%0d want we=%0d done=1", o.we, o.done, e.we); end
    n_assert++; if (o.ir_after !== 32'h0000_0013 || !o.ir_ok) begin n_fail++; $display("FAIL basic_ir got %h want 00000013", o.ir_after); end
    n_assert++; if (!o.pc_stable) begin n_fail++; $display("FAIL basic_pc_stable got change want none"); end
  endtask

  task automatic test_imem_wait;
    obs_t o; exp_t e;
    run_instr(32'h00A0_0093, 3, 1'b0, 1'b1, 2'b00, 32'h0, 0, 1'b0, 40, o);
    e = sb.pop_front();
    n_assert++; if (o.ireq !== e.ireq || !o.addr_ok) begin n_fail++; $display("FAIL wait_req_hold got %0d cyc addr_ok=%b want %0d cyc", o.ireq, o.addr_ok, e.ireq); end
    n_assert++; if (!o.ir_ok) begin n_fail++; $display("FAIL wait_ir_load got early/late load want load on ack only"); end
    n_assert++; if (o.cycles !== e.cycles || o.timed_out) begin n_fail++; $display("FAIL wait_latency got %0d want %0d", o.cycles, e.cycles); end
    n_assert++; if (o.pc_after !== e.pc || !o.pc_stable) begin n_fail++; $display("FAIL wait_pc got %h want %h", o.pc_after, e.pc); end
  endtask

  task automatic test_mem;
    obs_t o; exp_t e;
    run_instr(32'h0000_A103, 0, 1'b1, 1'b1, 2'b00, 32'h0, 2, 1'b0, 40, o);
    e = sb.pop_front();
    n_assert++; if (o.dreq !== e.dreq) begin n_fail++; $display("FAIL mem_dreq_hold got %0d want %0d", o.dreq, e.dreq); end
    n_assert++; if (o.cycles !== e.cycles || o.timed_out) begin n_fail++; $display("FAIL mem_latency got %0d want %0d", o.cycles, e.cycles); end
    n_assert++; if (o.we !== e.we || o.pc_after !== e.pc) begin n_fail++; $display("FAIL mem_retire got we=%0d pc=%h want we=%0d pc=%h", o.we, o.pc_after, e.we, e.pc); end
    // store, no writeback, with stray acks while requests are low
    run_instr(32'h0020_A023, 0, 1'b1, 1'b0, 2'b00, 32'h0, 0, 1'b1, 40, o);
    e = sb.pop_front();
    n_assert++; if (o.cycles !== e.cycles || o.timed_out) begin n_fail++; $display("FAIL store_latency got %0d want %0d", o.cycles, e.cycles); end
    n_assert++; if (o.we !== e.we || o.dreq !== e.dreq) begin n_fail++; $display("FAIL store_we got we=%0d dreq=%0d want we=%0d dreq=%0d", o.we, o.dreq, e.we, e.dreq); end
    n_assert++; if (!o.ir_ok || o.pc_after !== e.pc) begin n_fail++; $display("FAIL store_spurious got ir_ok=%b pc=%h want pc=%h", o.ir_ok, o.pc_after, e.pc); end
  endtask

  task automatic test_branch;
    obs_t o; exp_t e;
    run_instr(32'h0000_0067, 0, 1'b0, 1'b1, 2'b10, 32'h0000_0105, 0, 1'b0, 40, o);
    e = sb.pop_front();
    n_assert++; if (o.pc_after !== e.pc || o.timed_out) begin n_fail++; $display("FAIL jalr_pc got %h want %h", o.pc_after, e.pc); end
    run_instr(32'h0000_0063, 0, 1'b0, 1'b0, 2'b01, 32'h0000_0200, 0, 1'b1, 40, o);
    e = sb.pop_front();
    n_assert++; if (o.pc_after !== e.pc || o.we !== e.we) begin n_fail++; $display("FAIL branch_pc got %h we=%0d want %h we=%0d", o.pc_after, o.we, e.pc, e.we); end
    run_instr(32'h0000_0013, 0, 1'b0, 1'b1, 2'b11, 32'h0000_0888, 0, 1'b0, 40, o);
    e = sb.pop_front();
    n_assert++; if (o.pc_after !== e.pc) begin n_fail++; $display("FAIL sel11_pc got %h want %h", o.pc_after, e.pc); end
  endtask

  task automatic test_wrap;
    obs_t o; exp_t e;
    run_instr(32'h0000_006F, 0, 1'b0, 1'b1, 2'b01, 32'hFFFF_FFFC, 0, 1'b0, 40, o);
    e = sb.pop_front();
    n_assert++; if (o.pc_after !== e.pc) begin n_fail++; $display("FAIL wrap_setup_pc got %h want %h", o.pc_after, e.pc); end
    run_instr(32'h0000_0013, 0, 1'b0, 1'b1, 2'b00, 32'h0, 0, 1'b0, 40, o);
    e = sb.pop_front();
    n_assert++; if (o.p4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus4 got %h want 00000000", o.p4); end
    n_assert++; if (o.pc_after !== e.pc) begin n_fail++; $display("FAIL wrap_pc got %h want %h", o.pc_after, e.pc); end
  endtask

  task automatic test_reset_mid;
    int dn, wn;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    step; step;
    n_assert++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_req got %b want 1", imem_req); end
    rst = 1'b1;
    step;
    n_assert++; if (imem_req !== 1'b0 || pc !== 32'h0) begin n_fail++; $display("FAIL midrst_drop got req=%b pc=%h want req=0 pc=00000000", imem_req, pc); end
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    step;
    imem_ack = 1'b0;
    n_assert++; if (ir !== 32'h0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_late_ack got ir=%h req=%b want ir=00000000 req=1", ir, imem_req); end
    dn = 0; wn = 0;
    for (int i = 0; i < 6; i++) begin
      if (instr_done) dn++;
      if (rf_we) wn++;
      step;
    end
    n_assert++; if (dn !== 0 || wn !== 0) begin n_fail++; $display("FAIL midrst_no_retire got done=%0d we=%0d want 0 0", dn, wn); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    model_pc = 32'h0; model_ir = 32'h0;
  endtask

  task automatic test_misalign;
    obs_t o; exp_t e;
    run_instr(32'h0000_0063, 0, 1'b0, 1'b1, 2'b01, 32'h0000_0202, 0, 1'b0, 12, o);
    e = sb.pop_front();
    n_assert++; if (o.timed_out !== e.trap) begin n_fail++; $display("FAIL misalign_retire got timed_out=%b want %b", o.timed_out, e.trap); end
    n_assert++; if (o.pc_after !== e.pc || o.we !== e.we) begin n_fail++; $display("FAIL misalign_pc got %h we=%0d want %h we=%0d", o.pc_after, o.we, e.pc, e.we); end
`ifdef MISALIGN_TRAP_EN
    repeat (3) step;
    n_assert++; if (trap !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL trap_sticky got trap=%b ireq=%b dreq=%b want 1 0 0", trap, imem_req, dmem_req); end
    n_assert++; if (pc !== model_pc || instr_done !== 1'b0) begin n_fail++; $display("FAIL trap_pc got %h want %h", pc, model_pc); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_assert++; if (trap !== 1'b0) begin n_fail++; $display("FAIL trap_clear got %b want 0", trap); end
`else
    n_assert++; if (trap !== 1'b0) begin n_fail++; $display("FAIL trap_tied got %b want 0", trap); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_imem_wait();
    test_mem();
    test_branch();
    test_wrap();
    test_reset_mid();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
